// File: rtl/serial_cmp_lsb.sv
// Bit-serial magnitude comparator, LSB first, WIDTH+1 cycles per compare.
// Ports: clk, reset, start, A, B, is_signed in; busy, done, L, E, G out.
module serial_cmp_lsb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] REL_EQ = 2'd0;
  localparam logic [1:0] REL_LT = 2'd1;
  localparam logic [1:0] REL_GT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [1:0]       r_rel;
  logic             r_l;
  logic             r_e;
  logic             r_g;

  logic             w_last;
  logic             w_inv;
  logic             w_accept;
  logic [1:0]       w_rel_next;

  // Later bits override earlier ones, so the last differing bit
  // (highest order) decides. The sign bit weighs negatively.
  always_comb begin
    w_last     = (r_cnt == LAST);
    w_inv      = w_last & r_sgn;
    w_accept   = (r_state != SHIFT) & start;
    w_rel_next = r_rel;
    unique case (1'b1)
      (r_a[0] & ~r_b[0]): w_rel_next = w_inv ? REL_LT : REL_GT;
      (~r_a[0] & r_b[0]): w_rel_next = w_inv ? REL_GT : REL_LT;
      default:            w_rel_next = r_rel;
    endcase
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? SHIFT : IDLE;
      DONE:    w_next = start ? SHIFT : IDLE;
      SHIFT:   w_next = w_last ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_rel   <= REL_EQ;
      r_l     <= 1'b0;
      r_e     <= 1'b1;
      r_g     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= A;
        r_b   <= B;
        r_sgn <= is_signed;
        r_cnt <= '0;
        r_rel <= REL_EQ;
      end else if (r_state == SHIFT) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + CW'(1);
        r_rel <= w_rel_next;
        if (w_last) begin
          r_l <= (w_rel_next == REL_LT);
          r_e <= (w_rel_next == REL_EQ);
          r_g <= (w_rel_next == REL_GT);
        end
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign L    = r_l;
  assign E    = r_e;
  assign G    = r_g;

endmodule

// File: tb/tb_serial_cmp_lsb.sv
// Self-checking bench for serial_cmp_lsb (WIDTH=32).
// Vector table, random model compare, abort/ignore/streaming sequences.
module tb_serial_cmp_lsb;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         is_signed;
  logic         busy;
  logic         done;
  logic         L;
  logic         E;
  logic         G;

  int errors;
  int checks;
  logic [2:0] prev_leg;

  serial_cmp_lsb #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .A(A),
    .B(B),
    .is_signed(is_signed),
    .busy(busy),
    .done(done),
    .L(L),
    .E(E),
    .G(G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [2:0]   leg;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic s);
    logic signed [W:0] x;
    logic signed [W:0] y;
    x = s ? {a[W-1], a} : {1'b0, a};
    y = s ? {b[W-1], b} : {1'b0, b};
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
    return 3'b010;
  endfunction

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2:0] exp);
    int bcnt;
    int cyc;
    @(negedge clk);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; is_signed = ~s;
    chk("hold_leg", {L, E, G}, prev_leg);
    bcnt = 0;
    cyc = 0;
    while (!done && cyc < W + 4) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("busy_len", bcnt, W);
    chk("done_time", cyc, W);
    chk("leg", {L, E, G}, exp);
    chk("busy_in_done", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("leg_idle", {L, E, G}, exp);
    prev_leg = exp;
  endtask

  vec_t vt[10];

  initial begin
    int ndone;
    int last_d;
    int bad_sp;
    int bad_busy;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    errors = 0;
    checks = 0;
    vt[0] = '{32'd5,        32'd3,        1'b0, 3'b001};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b001};
    vt[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b100};
    vt[3] = '{32'h00000102, 32'h00000001, 1'b0, 3'b001};
    vt[4] = '{32'h12345678, 32'h12345678, 1'b0, 3'b010};
    vt[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b100};
    vt[6] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b001};
    vt[7] = '{32'h00000000, 32'h00000000, 1'b1, 3'b010};
    vt[8] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b001};
    vt[9] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b100};

    reset = 1'b1; start = 1'b0; A = '0; B = '0; is_signed = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_leg", {L, E, G}, 3'b010);
    reset = 1'b0;
    prev_leg = 3'b010;

    for (int i = 0; i < 10; i++)
      run_one(vt[i].a, vt[i].b, vt[i].s, vt[i].leg);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra ^ (32'h1 << $urandom_range(0, 31));
      rs = 1'($urandom_range(0, 1));
      run_one(ra, rb, rs, ref_cmp(ra, rb, rs));
    end

    // start with new operands mid-compare must be ignored
    @(negedge clk);
    A = 32'd5; B = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    A = 32'd3; B = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 6;
    while (!done && ndone < W + 4) begin @(posedge clk); #1; ndone++; end
    chk("ign_time", ndone, W);
    chk("ign_leg", {L, E, G}, 3'b001);
    @(posedge clk); #1;
    chk("ign_idle", busy, 0);
    prev_leg = 3'b001;

    // reset mid-compare aborts with no done pulse
    @(negedge clk);
    A = 32'd1; B = 32'd9; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_leg", {L, E, G}, 3'b010);
    ndone = 0;
    repeat (W + 5) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    chk("abort_leg2", {L, E, G}, 3'b010);

    // continuous start: done every W+1 cycles, busy low only in DONE
    @(negedge clk);
    A = 32'h80000000; B = 32'h1; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; last_d = -1; bad_sp = 0; bad_busy = 0;
    for (int c = 0; c < 3 * (W + 1); c++) begin
      if (busy == done) bad_busy++;
      if (done) begin
        if (last_d >= 0 && c - last_d != W + 1) bad_sp++;
        last_d = c;
        ndone++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("stream_count", ndone, 3);
    chk("stream_space", bad_sp, 0);
    chk("stream_busy", bad_busy, 0);
    chk("stream_leg", {L, E, G}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_cmp_lsb.md
SERIAL_CMP_LSB -- requirements
Module: serial_cmp_lsb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width in bits, legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a comparison; sampled only when busy=0.
REQ-005 The block SHALL have port A, input, WIDTH bits: first operand; sampled only on an accepted start.
REQ-006 The block SHALL have port B, input, WIDTH bits: second operand; sampled only on an accepted start.
REQ-007 The block SHALL have port is_signed, input, 1 bit: 1 = two's-complement compare, 0 = unsigned; sampled only on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: comparison in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when L/E/G take a new result.
REQ-010 The block SHALL have port L, output, 1 bit: last result A<B.
REQ-011 The block SHALL have port E, output, 1 bit: last result A==B.
REQ-012 The block SHALL have port G, output, 1 bit: last result A>B.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, plus a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 In IDLE or DONE, start=1 at edge k SHALL load A, B and is_signed into internal shift registers, clear the counter, set the running relation to EQ, and enter SHIFT at edge k.
REQ-015 In IDLE or DONE, start=0 SHALL cause the FSM to go to or remain in IDLE.
REQ-016 busy SHALL be 1 exactly while in SHIFT.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 A, B and is_signed changes during SHIFT SHALL have no effect.
REQ-019 Each SHIFT cycle SHALL consume bit 0 (LSB-first) of each shift register as a and b, then shift both registers right by one.
REQ-020 Per consumed bit, relation update: a==b keeps the previous relation; a=1,b=0 sets GT; a=0,b=1 sets LT.
REQ-021 When the counter is WIDTH-1 (MSB) and the captured is_signed=1, the sense of REQ-020 SHALL be inverted: a=1,b=0 sets LT; a=0,b=1 sets GT.
REQ-022 The MSB-cycle update SHALL transition SHIFT to DONE, so SHIFT lasts exactly WIDTH cycles.
REQ-023 On entry to DONE (edge k+WIDTH), L/E/G SHALL be loaded from the final relation, and done SHALL be 1 for exactly that one cycle.
REQ-024 L/E/G SHALL change only at completion or reset, and SHALL hold their value through IDLE and through any following SHIFT.
REQ-025 Exactly one of L, E and G SHALL be 1 at all times.
REQ-026 Back-to-back operation: start in the DONE cycle SHALL be accepted, re-entering SHIFT without an IDLE cycle.

Reset
REQ-027 reset=1 at a rising edge SHALL force: FSM=IDLE, busy=0, done=0, L=0, E=1, G=0, counter=0, relation=EQ, shift registers=0.
REQ-028 reset SHALL take priority over start and over any in-flight comparison; an aborted comparison SHALL never produce a done pulse.

Verification
REQ-029 Scenario: unsigned A=5, B=3, start at edge k -> busy=1 for 32 cycles; done=1 only in the cycle after edge k+32; G=1, L=0, E=0.
REQ-030 Scenario: A=0xFFFFFFFF, B=0x00000001 -> with is_signed=0 the result is G=1; with is_signed=1 the result is L=1.
REQ-031 Scenario: A=0x00000102, B=0x00000001, unsigned -> G=1 (higher-order difference overrides the lower-order B>A); A=B=0x12345678 -> E=1.
REQ-032 Scenario: A=0x80000000, B=0x7FFFFFFF, is_signed=1 -> L=1; same operands with is_signed=0 -> G=1.
REQ-033 Scenario: start pulsed with new operands at SHIFT cycle 5 -> ignored, and the original result is delivered on time; reset asserted at SHIFT cycle 10 -> next cycle busy=0, E=1, and no done pulse follows.
REQ-034 Scenario: start held high continuously -> done pulses every 33 cycles, and busy drops only during the DONE cycles.
